// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared width, flag-index constants and flag type for the adder.
// Revision : 1.0  initial release
// ============================================================================
package adder_pkg;

   localparam int ADDER_WIDTH = 16;

   // Bit positions inside the packed {N,Z,C,V} flag vector
   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;

   typedef logic [3:0] adder_flags_t;

   function automatic adder_flags_t pack_flags(
      input logic n,
      input logic z,
      input logic c,
      input logic v
   );
      adder_flags_t f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_cla4.sv
`default_nettype none
// ============================================================================
// Module   : cla4
// Purpose  : 4-bit carry-lookahead slice with group propagate/generate.
// Revision : 1.0  initial release
// ============================================================================
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       p,
   output logic       g
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [3:1] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Every internal carry is a flat sum-of-products of the slice inputs
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign p = &w_p;
   assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign cout = g | (p & cin);
   assign s    = w_p ^ {w_c[3], w_c[2], w_c[1], cin};

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Purpose  : Combinational add with registered result and {N,Z,C,V} flags.
//            ADDER_SUB_EN adds a 'sub' input selecting a - b.
// Revision : 1.0  initial release
// ============================================================================
module adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic [WIDTH-1:0] result_q,
   output adder_flags_t     flags_q
);

   localparam int c_nslice = WIDTH / 4;

   logic [WIDTH-1:0]    w_b_eff;
   logic                w_cin;
   logic [c_nslice:0]   w_c;
   logic [c_nslice-1:0] w_gp;
   logic [c_nslice-1:0] w_gg;
   logic [c_nslice-1:0] w_cout;
   logic                w_unused_cout;
   logic                w_zero;
   adder_flags_t        w_flags;

   logic [WIDTH-1:0]    r_result_q;
   adder_flags_t        r_flags_q;

   // Subtraction is a + ~b + 1, so the inverted operand also feeds ovf
`ifdef ADDER_SUB_EN
   assign w_b_eff = b ^ {WIDTH{sub}};
   assign w_cin   = sub;
`else
   assign w_b_eff = b;
   assign w_cin   = 1'b0;
`endif

   assign w_c[0] = w_cin;

   generate
      for (genvar i = 0; i < c_nslice; i++) begin : g_slice
         cla4 u_cla4 (
            .a    (a[4*i +: 4]),
            .b    (w_b_eff[4*i +: 4]),
            .cin  (w_c[i]),
            .s    (result[4*i +: 4]),
            .cout (w_cout[i]),
            .p    (w_gp[i]),
            .g    (w_gg[i])
         );
         // Slice-to-slice carry rippled from the group propagate/generate
         assign w_c[i+1] = w_gg[i] | (w_gp[i] & w_c[i]);
      end
   endgenerate

   // The slice couts duplicate the group ripple; only the top one is driven out
   assign w_unused_cout = ^w_cout;

   assign carry  = w_c[c_nslice];
   assign ovf    = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
   assign w_zero = (result == '0);

   assign w_flags = pack_flags(result[WIDTH-1], w_zero, carry, ovf);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result_q <= '0;
         r_flags_q  <= '0;
      end else begin
         r_result_q <= result;
         r_flags_q  <= w_flags;
      end
   end

   assign result_q = r_result_q;
   assign flags_q  = r_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder
// Purpose  : Directed and random self-checking bench for adder.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder;

   localparam int c_width = 16;

   logic               clk;
   logic               rst;
   logic [c_width-1:0] a;
   logic [c_width-1:0] b;
`ifdef ADDER_SUB_EN
   logic               sub;
`endif
   logic [c_width-1:0] result;
   logic               carry;
   logic               ovf;
   logic [c_width-1:0] result_q;
   logic [3:0]         flags_q;

   int n_checks = 0;
   int n_errors = 0;

   adder #(.WIDTH(c_width)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
`ifdef ADDER_SUB_EN
      .sub      (sub),
`endif
      .result   (result),
      .carry    (carry),
      .ovf      (ovf),
      .result_q (result_q),
      .flags_q  (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive a vector, check the combinational outputs, then the registered copy
   task automatic run_vec(input string tag,
                          input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] er, input logic ec, input logic ev,
                          input logic [3:0] ef);
      @(negedge clk);
      a = va;
      b = vb;
      #1;
      check({tag, ".result"}, {16'h0, result}, {16'h0, er});
      check({tag, ".carry"},  {31'h0, carry},  {31'h0, ec});
      check({tag, ".ovf"},    {31'h0, ovf},    {31'h0, ev});
      @(posedge clk);
      #1;
      check({tag, ".result_q"}, {16'h0, result_q}, {16'h0, er});
      check({tag, ".flags_q"},  {28'h0, flags_q},  {28'h0, ef});
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [16:0] rsum;
      logic        rv;

      rst = 1'b1;
      a   = '0;
      b   = '0;
`ifdef ADDER_SUB_EN
      sub = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset.result_q", {16'h0, result_q}, 32'h0);
      check("reset.flags_q",  {28'h0, flags_q},  32'h0);
      @(negedge clk);
      rst = 1'b0;

      //      tag      a         b         result    c     v     {N,Z,C,V}
      run_vec("v0",    16'h0022, 16'h10A4, 16'h10C6, 1'b0, 1'b0, 4'b0000);
      run_vec("v1",    16'h0020, 16'h0101, 16'h0121, 1'b0, 1'b0, 4'b0000);
      run_vec("v2",    16'hEE00, 16'h00FF, 16'hEEFF, 1'b0, 1'b0, 4'b1000);
      run_vec("v3",    16'h1100, 16'h1001, 16'h2101, 1'b0, 1'b0, 4'b0000);
      run_vec("wrap",  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'b0110);
      run_vec("sovf",  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 4'b1001);
      run_vec("novf",  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 4'b0111);
      run_vec("cry",   16'hF000, 16'h1234, 16'h0234, 1'b1, 1'b0, 4'b0010);

      // Synchronous reset clears registers while the sum keeps tracking inputs
      @(negedge clk);
      rst = 1'b1;
      a   = 16'h1234;
      b   = 16'h1111;
      #1;
      check("rst.result", {16'h0, result}, 32'h2345);
      @(posedge clk);
      #1;
      check("rst.result_q", {16'h0, result_q}, 32'h0);
      check("rst.flags_q",  {28'h0, flags_q},  32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel.result_q", {16'h0, result_q}, 32'h2345);
      check("rel.flags_q",  {28'h0, flags_q},  32'h0);

`ifdef ADDER_SUB_EN
      @(negedge clk);
      sub = 1'b1;
      a   = 16'h0005;
      b   = 16'h0007;
      #1;
      check("sub.result", {16'h0, result}, 32'hFFFE);
      check("sub.carry",  {31'h0, carry},  32'h0);
      check("sub.ovf",    {31'h0, ovf},    32'h0);
      @(posedge clk);
      #1;
      check("sub.flags_q", {28'h0, flags_q}, 32'h8);
      @(negedge clk);
      a = 16'h0007;
      b = 16'h0005;
      #1;
      check("sub2.result", {16'h0, result}, 32'h0002);
      check("sub2.carry",  {31'h0, carry},  32'h1);
      @(negedge clk);
      sub = 1'b0;
`endif

      for (int i = 0; i < 1000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rsum = {1'b0, ra} + {1'b0, rb};
         rv   = (ra[15] == rb[15]) && (rsum[15] != ra[15]);
         @(negedge clk);
         a = ra;
         b = rb;
         #1;
         check("rnd.result", {16'h0, result}, {16'h0, rsum[15:0]});
         check("rnd.carry",  {31'h0, carry},  {31'h0, rsum[16]});
         check("rnd.ovf",    {31'h0, ovf},    {31'h0, rv});
         @(posedge clk);
         #1;
         check("rnd.flags_q", {28'h0, flags_q},
               {28'h0, rsum[15], (rsum[15:0] == 16'h0), rsum[16], rv});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
